// File: rtl/rgbled_ctrl_if.sv
// Register-write bus between the CPU, the LEDDA sequencer and the LED driver.
// The sequencer is the slave of the CPU side and drives the led_* lines.
interface rgbled_ctrl_if;
  logic [7:0] dbw;
  logic [3:0] addr;
  logic       we;
  logic [7:0] dbr;
  logic [7:0] led_dat;
  logic [3:0] led_addr;
  logic       led_we;

  modport master (
    output dbw, addr, we,
    input  dbr, led_dat, led_addr, led_we
  );

  modport slave (
    input  dbw, addr, we,
    output dbr, led_dat, led_addr, led_we
  );
endinterface

// File: rtl/rgbled_ctrl.sv
// LEDDA sequencer: programs the LED driver after reset, then forwards queued CPU writes.
// Optional macro RGBLED_SHADOW_EN adds readback shadows for addresses 1..3 and a status word.
module rgbled_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  INIT_BR    = 8'hED,
  parameter logic [7:0]  INIT_ONR   = 8'h00,
  parameter logic [7:0]  INIT_OFR   = 8'h00,
  parameter logic [7:0]  INIT_CR0   = 8'hC8
) (
  input  logic          clk,
  input  logic          rst,
  rgbled_ctrl_if.slave  bus,
  output logic          busy,
  output logic          init_done,
  output logic          overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_INIT, S_INIT_GAP, S_IDLE, S_WR, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    led_dat_q, led_dat_d;
  logic [3:0]    led_addr_q, led_addr_d;
  logic          led_we_q, led_we_d;

  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          pop, push;

  // Init table entry: {address, data}
  function automatic logic [11:0] init_entry(input logic [3:0] i);
    case (i)
      4'd0:    init_entry = {4'h8, 8'h00};
      4'd1:    init_entry = {4'h9, INIT_BR};
      4'd2:    init_entry = {4'hA, INIT_ONR};
      4'd3:    init_entry = {4'hB, INIT_OFR};
      4'd4:    init_entry = {4'h1, 8'h00};
      4'd5:    init_entry = {4'h2, 8'h00};
      4'd6:    init_entry = {4'h3, 8'h00};
      default: init_entry = {4'h8, INIT_CR0};
    endcase
  endfunction

  // A full queue still accepts a write when the head leaves on the same edge
  assign pop  = (state_q == S_IDLE) && (cnt_q != '0);
  assign push = bus.we && ((cnt_q < CW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.addr, bus.dbw};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      led_dat_q   <= '0;
      led_addr_q  <= '0;
      led_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
      led_dat_q   <= led_dat_d;
      led_addr_q  <= led_addr_d;
      led_we_q    <= led_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:     state_d = (idx_q == 4'd8) ? S_IDLE : S_INIT_GAP;
      S_INIT_GAP: state_d = S_INIT;
      S_IDLE:     if (cnt_q != '0) state_d = S_WR;
      S_WR:       state_d = S_GAP;
      S_GAP:      state_d = S_IDLE;
      default:    state_d = S_INIT;
    endcase
  end

  // Next values of the registered driver outputs and bookkeeping flags
  always_comb begin
    led_we_d    = 1'b0;
    led_dat_d   = led_dat_q;
    led_addr_d  = led_addr_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    ovf_d       = ovf_q | (bus.we & ~push);
    case (state_q)
      S_INIT: begin
        if (idx_q == 4'd8) begin
          init_done_d = 1'b1;
        end else begin
          led_we_d                = 1'b1;
          {led_addr_d, led_dat_d} = init_entry(idx_q);
          idx_d                   = idx_q + 4'd1;
        end
      end
      S_IDLE: begin
        if (pop) begin
          led_we_d                = 1'b1;
          {led_addr_d, led_dat_d} = mem_q[rd_ptr_q];
        end
      end
      default: ;
    endcase
  end

  assign bus.led_dat  = led_dat_q;
  assign bus.led_addr = led_addr_q;
  assign bus.led_we   = led_we_q;
  assign init_done    = init_done_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q != S_IDLE) || (cnt_q != '0);

`ifdef RGBLED_SHADOW_EN
  logic [7:0] sh1_q, sh2_q, sh3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh1_q <= '0;
      sh2_q <= '0;
      sh3_q <= '0;
    end else if (led_we_d) begin
      case (led_addr_d)
        4'd1:    sh1_q <= led_dat_d;
        4'd2:    sh2_q <= led_dat_d;
        4'd3:    sh3_q <= led_dat_d;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.dbr = '0;
    case (bus.addr)
      4'd1:    bus.dbr = sh1_q;
      4'd2:    bus.dbr = sh2_q;
      4'd3:    bus.dbr = sh3_q;
      4'd4:    bus.dbr = {5'b0, ovf_q, init_done_q, busy};
      default: bus.dbr = '0;
    endcase
  end
`else
  assign bus.dbr = '0;
`endif

endmodule

// File: tb/tb_rgbled_ctrl.sv
// Bench for rgbled_ctrl: directed vector table, hand sequences and random traffic
// checked against a write-scheduling reference model.
module tb_rgbled_ctrl;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, init_done, overflow;

  rgbled_ctrl_if bus ();

  rgbled_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .init_done (init_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_strobes = 0;

  // Reference model: each accepted write is given the edge at which it leaves
  int          cyc;
  int          pop_e[$];
  logic [11:0] ent[$];
  int          n_drop;
  logic [11:0] last_ad;
  logic [7:0]  sh [16];
  logic [11:0] init_tab [8] = '{12'h800, 12'h9ED, 12'hA00, 12'hB00,
                                12'h100, 12'h200, 12'h300, 12'h8C8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    pop_e.delete();
    ent.delete();
    n_drop  = 0;
    last_ad = '0;
    for (int i = 0; i < 16; i++) sh[i] = '0;
  endtask

  task automatic model_push(input int e, input logic [3:0] a, input logic [7:0] d);
    int  inq;
    bit  popnow;
    int  p;
    inq    = 0;
    popnow = 0;
    foreach (pop_e[i]) begin
      if (pop_e[i] >= e) inq++;
      if (pop_e[i] == e) popnow = 1;
    end
    if (inq < DEPTH || popnow) begin
      p = (e + 1 < 18) ? 18 : e + 1;
      if (pop_e.size() > 0 && pop_e[$] + 3 > p) p = pop_e[$] + 3;
      pop_e.push_back(p);
      ent.push_back({a, d});
    end else begin
      n_drop++;
    end
  endtask

  task automatic model_check();
    logic        ew, eb;
    logic [11:0] ead;
    logic [7:0]  edbr;
    ew  = 1'b0;
    ead = last_ad;
    if (cyc <= 15 && cyc[0]) begin
      ew  = 1'b1;
      ead = init_tab[3'((cyc - 1) / 2)];
    end
    foreach (pop_e[i]) if (pop_e[i] == cyc) begin
      ew  = 1'b1;
      ead = ent[i];
    end
    eb = (cyc < 17);
    foreach (pop_e[i]) if (pop_e[i] >= cyc - 1) eb = 1'b1;
    if (ew) begin
      last_ad = ead;
      if (ead[11:8] >= 4'd1 && ead[11:8] <= 4'd3) sh[ead[11:8]] = ead[7:0];
    end
`ifdef RGBLED_SHADOW_EN
    case (bus.addr)
      4'd1, 4'd2, 4'd3: edbr = sh[bus.addr];
      4'd4:             edbr = {5'b0, (n_drop > 0), (cyc >= 17), eb};
      default:          edbr = 8'h00;
    endcase
`else
    edbr = 8'h00;
`endif
    if (bus.led_we) n_strobes++;
    chk("m_led_we",    32'(bus.led_we),   32'(ew));
    chk("m_led_addr",  32'(bus.led_addr), 32'(ead[11:8]));
    chk("m_led_dat",   32'(bus.led_dat),  32'(ead[7:0]));
    chk("m_busy",      32'(busy),         32'(eb));
    chk("m_init_done", 32'(init_done),    32'(cyc >= 17));
    chk("m_overflow",  32'(overflow),     32'(n_drop > 0));
    chk("m_dbr",       32'(bus.dbr),      32'(edbr));
  endtask

  // One clock: drive inputs, take the edge, then compare at the falling edge
  task automatic cycle(input logic w, input logic [3:0] a, input logic [7:0] d);
    bus.we   = w;
    bus.addr = a;
    bus.dbw  = d;
    @(posedge clk);
    cyc++;
    if (w) model_push(cyc, a, d);
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 4'h0;
    bus.dbw  = 8'h00;
    #1;
    chk("rst_led_we",    32'(bus.led_we),   32'd0);
    chk("rst_led_addr",  32'(bus.led_addr), 32'd0);
    chk("rst_led_dat",   32'(bus.led_dat),  32'd0);
    chk("rst_init_done", 32'(init_done),    32'd0);
    chk("rst_overflow",  32'(overflow),     32'd0);
    chk("rst_dbr",       32'(bus.dbr),      32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] a;
    logic [7:0] d;
    logic       exp_we;
    logic [3:0] exp_a;
    logic [7:0] exp_d;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vt [20];
  int   n0;

  initial begin
    // Edge 1..20 after release; write (2,55) queued at edge 2 during init
    vt[0]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h8, 8'h00, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 4'h2, 8'h55, 1'b0, 4'h8, 8'h00, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'hED, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h9, 8'hED, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hA, 8'h00, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'hA, 8'h00, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hB, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'hB, 8'h00, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 8'h00, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h1, 8'h00, 1'b0, 1'b1};
    vt[10] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h2, 8'h00, 1'b0, 1'b1};
    vt[11] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1};
    vt[12] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'h00, 1'b0, 1'b1};
    vt[13] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h3, 8'h00, 1'b0, 1'b1};
    vt[14] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h8, 8'hC8, 1'b0, 1'b1};
    vt[15] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h8, 8'hC8, 1'b0, 1'b1};
    vt[16] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h8, 8'hC8, 1'b1, 1'b1};
    vt[17] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h2, 8'h55, 1'b1, 1'b1};
    vt[18] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h2, 8'h55, 1'b1, 1'b1};
    vt[19] = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h2, 8'h55, 1'b1, 1'b0};

    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].we, vt[i].a, vt[i].d);
      chk("tbl_led_we",    32'(bus.led_we),   32'(vt[i].exp_we));
      chk("tbl_led_addr",  32'(bus.led_addr), 32'(vt[i].exp_a));
      chk("tbl_led_dat",   32'(bus.led_dat),  32'(vt[i].exp_d));
      chk("tbl_init_done", 32'(init_done),    32'(vt[i].exp_done));
      chk("tbl_busy",      32'(busy),         32'(vt[i].exp_busy));
    end

    // Single write in IDLE: strobe one cycle after the write edge, exactly once
    cycle(1'b1, 4'h1, 8'hFF);
    n0 = n_strobes;
    cycle(1'b0, 4'h0, 8'h00);
    chk("single_we",   32'(bus.led_we),   32'd1);
    chk("single_addr", 32'(bus.led_addr), 32'h1);
    chk("single_dat",  32'(bus.led_dat),  32'hFF);
    repeat (4) cycle(1'b0, 4'h0, 8'h00);
    chk("single_count", 32'(n_strobes - n0), 32'd1);

    // Five back-to-back writes in IDLE: head pops at once, nothing dropped
    n0 = n_strobes;
    for (int k = 1; k <= 5; k++) cycle(1'b1, 4'h1, 8'(k));
    repeat (16) cycle(1'b0, 4'h0, 8'h00);
    chk("burst_idle_count", 32'(n_strobes - n0), 32'd5);
    chk("burst_idle_ovf",   32'(overflow),       32'd0);

    // Shadow readback of address 3
    cycle(1'b1, 4'h3, 8'hA7);
    repeat (4) cycle(1'b0, 4'h0, 8'h00);
    cycle(1'b0, 4'h3, 8'h00);
`ifdef RGBLED_SHADOW_EN
    chk("shadow3", 32'(bus.dbr), 32'hA7);
`else
    chk("shadow3", 32'(bus.dbr), 32'h00);
`endif

    // Reset while a queued write is on the driver bus
    cycle(1'b1, 4'h2, 8'h11);
    cycle(1'b1, 4'h2, 8'h22);
    chk("pre_rst_we", 32'(bus.led_we), 32'd1);
    do_reset();

    // Burst during init: fifth write dropped, four strobes after the table
    n0 = n_strobes;
    for (int k = 1; k <= 5; k++) cycle(1'b1, 4'h1, 8'(k));
    chk("burst_init_ovf", 32'(overflow), 32'd1);
    repeat (30) cycle(1'b0, 4'h0, 8'h00);
    chk("burst_init_count", 32'(n_strobes - n0), 32'd12);
    cycle(1'b0, 4'h4, 8'h00);
`ifdef RGBLED_SHADOW_EN
    chk("status_word", 32'(bus.dbr), 32'h06);
`else
    chk("status_word", 32'(bus.dbr), 32'h00);
`endif

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    repeat (40) cycle(1'b0, 4'($urandom_range(0, 15)), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgbled_ctrl.md
Name: rgbled_ctrl

Overview:
Bus-side sequencer that sits directly upstream of the RGB LED driver and feeds its LEDDA register-write interface: data byte, 4-bit address, strobe.
- After reset it autonomously programs the LEDDA block: disable, prescaler, on/off times, zero PWM, enable.
- It then forwards CPU register writes through a small FIFO, guaranteeing one write strobe per entry with a mandatory idle gap.
- It exposes busy, init_done and overflow status.

Parameters:
FIFO_DEPTH, 4, CPU write queue entries (power of two, 2..16)
INIT_BR, 8'hED, LEDDBR prescaler value written at init
INIT_ONR, 8'h00, LEDDONR value written at init
INIT_OFR, 8'h00, LEDDOFR value written at init
INIT_CR0, 8'hC8, LEDDCR0 enable value written last at init

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
dbw  in  8  CPU write data
addr  in  4  CPU register address
we  in  1  CPU write strobe, one cycle per write
dbr  out  8  shadow readback (see Optional Feature)
led_dat  out  8  data to LED driver dbw
led_addr  out  4  address to LED driver addr
led_we  out  1  write strobe to LED driver we
busy  out  1  init running, FIFO non-empty, or write/gap in progress
init_done  out  1  init sequence complete
overflow  out  1  sticky: a CPU write was dropped

Behaviour:
- Reset (rst low, async): led_dat=0, led_addr=0, led_we=0, init_done=0, overflow=0, dbr=0, FIFO empty, FSM=INIT, init index=0. busy=1 from the first edge after release.
- All led_* outputs are registered. No combinational path from CPU inputs to led_*.
- FSM states: INIT, INIT_GAP, IDLE, WR, GAP.
- INIT: drive the next entry of the init table with led_we=1 for exactly one cycle, then go to INIT_GAP (led_we=0, one cycle). Advance the index. After the last entry, go to IDLE and set init_done=1, which then holds until reset.
- Init table, in order:
  - (8,00)
  - (9,INIT_BR)
  - (A,INIT_ONR)
  - (B,INIT_OFR)
  - (1,00)
  - (2,00)
  - (3,00)
  - (8,INIT_CR0)
- Init totals 8 writes and 16 cycles. init_done rises at the 17th edge after reset release.
- IDLE: if the FIFO is non-empty, pop at this edge, load led_dat/led_addr, set led_we=1, and go to WR. Otherwise stay in IDLE.
- WR: one cycle. Clear led_we and go to GAP.
- GAP: one cycle, then return to IDLE. Back-to-back queued writes therefore strobe every 3 cycles (IDLE pop, WR, GAP).
- Latency from an empty FIFO in IDLE: we sampled at edge k, pop at edge k+1, led_we high between edges k+1 and k+2.
- CPU push: we=1 at an edge pushes {addr,dbw}. This happens in every state, including INIT, so writes queue during init and drain after init_done.
- Full FIFO:
  - Push accepted only if count<FIFO_DEPTH, or if a pop occurs at the same edge.
  - Otherwise the write is dropped and overflow is set.
  - overflow clears only on reset.
- Simultaneous push and pop: count unchanged; order preserved.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- busy = (state!=IDLE) | (count!=0).
- Reset mid-write: led_we drops immediately, queued writes are discarded, and init reruns.

Optional Feature:
RGBLED_SHADOW_EN
- With it: three 8-bit shadow registers hold the last values written by the FSM (init or FIFO) to addresses 1, 2 and 3.
  - A shadow updates on the same edge led_we is set for that address.
  - dbr is combinational from addr: addr 1/2/3 return the shadow; addr 4 returns {5'b0, overflow, init_done, busy}; all others return 0.
  - Shadows reset to 0.
- Without it: dbr is constant 0, and no shadow flops are synthesized.

Test Plan:
- Reset release, no CPU activity -> 8 led_we pulses at cycles 1,3,...,15 carrying (8,00),(9,ED),(A,00),(B,00),(1,00),(2,00),(3,00),(8,C8). init_done=1 after edge 17; busy=0 after that.
- After init, single write addr=1 dbw=FF at edge k -> led_we=1 with led_addr=1, led_dat=FF between edges k+1 and k+2. Exactly one pulse.
- Write (2,55) at reset release+2 (during init) -> queued; emitted as the first strobe after the init table completes, never interleaved with it.
- Five back-to-back writes (1,01)..(1,05) with FIFO_DEPTH=4 in IDLE -> first pops immediately, so all five are emitted in order 3 cycles apart and overflow stays 0. Same burst during INIT -> fifth write dropped, overflow=1, four strobes after init.
- Assert rst low in the middle of a queued burst -> led_we=0 asynchronously, init_done=0, FIFO empty. After release the init sequence repeats exactly and no stale entries are emitted.
- With RGBLED_SHADOW_EN: write (3,A7), wait for the strobe, then set addr=3 -> dbr=A7. Set addr=4 after an overflow -> dbr=8'h06 when idle. Without the macro, dbr=00 in all cases.
